// File: rtl/y86_fetch_assembler_if.sv
// y86_fetch_assembler_if
// Byte-wide instruction memory read port used by the fetch assembler.
//   mem_req   fetch unit -> memory  byte read request, held until acknowledged
//   mem_addr  fetch unit -> memory  byte address, stable while mem_req is high
//   mem_ack   memory -> fetch unit  mem_byte is valid this cycle
//   mem_byte  memory -> fetch unit  returned instruction byte
// master: the fetch unit; slave: the memory.
interface y86_fetch_assembler_if #(
  parameter int DATA_WID = 64
);
  logic                mem_req;
  logic [DATA_WID-1:0] mem_addr;
  logic                mem_ack;
  logic [7:0]          mem_byte;

  modport master (
    output mem_req,
    output mem_addr,
    input  mem_ack,
    input  mem_byte
  );

  modport slave (
    input  mem_req,
    input  mem_addr,
    output mem_ack,
    output mem_byte
  );
endinterface

// File: rtl/y86_fetch_assembler.sv
// y86_fetch_assembler
// Byte-serial Y86-64 instruction fetch. From a start PC it reads instruction
// bytes one per acknowledged request, sizes the instruction from its first
// byte, collects exactly that many bytes and presents the decoded fields
// together with the next PC.
// Ports:
//   clk, rst     clock (rising edge) and asynchronous active-high reset
//   start        begin a fetch at pc_in (only honoured while idle)
//   flush        abort any fetch in progress; no result is produced
//   pc_in        address of the first instruction byte
//   mem          byte memory read port (master side)
//   busy         a fetch is in progress (FETCH or DONE)
//   valid        one-cycle pulse when the fields below are updated
//   instr_err    one-cycle pulse with valid for an illegal icode (C..F)
//   icode, ifun  instruction code / function from byte 0
//   rA, rB       register specifiers (F when the instruction has none)
//   valC         little-endian constant word (0 when absent)
//   valP         next PC (base+length; base for halt and illegal icodes)
module y86_fetch_assembler #(
  parameter int DATA_WID = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  flush,
  input  logic [DATA_WID-1:0]   pc_in,
  y86_fetch_assembler_if.master mem,
  output logic                  busy,
  output logic                  valid,
  output logic                  instr_err,
  output logic [3:0]            icode,
  output logic [3:0]            ifun,
  output logic [3:0]            rA,
  output logic [3:0]            rB,
  output logic [DATA_WID-1:0]   valC,
  output logic [DATA_WID-1:0]   valP
);

  typedef enum logic [1:0] {IDLE, FETCH, DONE} state_t;

  state_t              state;
  logic [DATA_WID-1:0] base;
  logic [3:0]          cnt;

  // Fields collected so far for the instruction being fetched.
  logic [3:0]          wk_icode, wk_ifun, wk_ra, wk_rb;
  logic [DATA_WID-1:0] wk_valc;

  // Working fields with the byte on mem_byte merged in.
  logic [3:0]          nx_icode, nx_ifun, nx_ra, nx_rb;
  logic [DATA_WID-1:0] nx_valc;
  logic [DATA_WID-1:0] nx_valp;

  logic [3:0]          cur_icode;
  logic [3:0]          cur_len;
  logic [2:0]          cidx;
  logic                last_byte;

  function automatic logic [3:0] instr_len(input logic [3:0] ic);
    case (ic)
      4'h0, 4'h1, 4'h9:          return 4'd1;
      4'h2, 4'h6, 4'hA, 4'hB:    return 4'd2;
      4'h3, 4'h4, 4'h5:          return 4'd10;
      4'h7, 4'h8:                return 4'd9;
      default:                   return 4'd1;
    endcase
  endfunction

  function automatic logic has_regs(input logic [3:0] ic);
    case (ic)
      4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'hA, 4'hB: return 1'b1;
      default:                                  return 1'b0;
    endcase
  endfunction

  function automatic logic is_illegal(input logic [3:0] ic);
    return ic[3] & ic[2];
  endfunction

  always_comb begin
    // On byte 0 the icode is only on the bus, so the length must come from it.
    cur_icode = (cnt == 4'd0) ? mem.mem_byte[7:4] : wk_icode;
    cur_len   = instr_len(cur_icode);
    last_byte = ((cnt + 4'd1) == cur_len);

    // Constant bytes follow the register byte when there is one. The 3-bit
    // wrap gives the right index for both layouts (cnt 2..9 or 1..8).
    cidx = cnt[2:0] - (has_regs(wk_icode) ? 3'd2 : 3'd1);

    nx_icode = wk_icode;
    nx_ifun  = wk_ifun;
    nx_ra    = wk_ra;
    nx_rb    = wk_rb;
    nx_valc  = wk_valc;
    if (cnt == 4'd0) begin
      nx_icode = mem.mem_byte[7:4];
      nx_ifun  = mem.mem_byte[3:0];
      nx_ra    = 4'hF;
      nx_rb    = 4'hF;
      nx_valc  = '0;
    end else if (has_regs(wk_icode) && (cnt == 4'd1)) begin
      nx_ra = mem.mem_byte[7:4];
      nx_rb = mem.mem_byte[3:0];
    end else begin
      nx_valc[{cidx, 3'b000} +: 8] = mem.mem_byte;
    end

    // Halt and illegal instructions leave the PC where it is.
    if ((cur_icode == 4'h0) || is_illegal(cur_icode))
      nx_valp = base;
    else
      nx_valp = base + DATA_WID'(cur_len);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      base         <= '0;
      cnt          <= '0;
      wk_icode     <= '0;
      wk_ifun      <= '0;
      wk_ra        <= '0;
      wk_rb        <= '0;
      wk_valc      <= '0;
      mem.mem_req  <= 1'b0;
      mem.mem_addr <= '0;
      busy         <= 1'b0;
      valid        <= 1'b0;
      instr_err    <= 1'b0;
      icode        <= '0;
      ifun         <= '0;
      rA           <= '0;
      rB           <= '0;
      valC         <= '0;
      valP         <= '0;
    end else if (flush) begin
      // Abort wins over start and over a same-cycle ack; result registers
      // keep whatever the last completed fetch left in them.
      state       <= IDLE;
      mem.mem_req <= 1'b0;
      busy        <= 1'b0;
      valid       <= 1'b0;
      instr_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          valid     <= 1'b0;
          instr_err <= 1'b0;
          if (start) begin
            base         <= pc_in;
            cnt          <= '0;
            mem.mem_addr <= pc_in;
            mem.mem_req  <= 1'b1;
            busy         <= 1'b1;
            state        <= FETCH;
          end
        end
        FETCH: begin
          if (mem.mem_ack) begin
            wk_icode     <= nx_icode;
            wk_ifun      <= nx_ifun;
            wk_ra        <= nx_ra;
            wk_rb        <= nx_rb;
            wk_valc      <= nx_valc;
            cnt          <= cnt + 4'd1;
            mem.mem_addr <= base + DATA_WID'(cnt + 4'd1);
            if (last_byte) begin
              mem.mem_req <= 1'b0;
              valid       <= 1'b1;
              instr_err   <= is_illegal(nx_icode);
              icode       <= nx_icode;
              ifun        <= nx_ifun;
              rA          <= nx_ra;
              rB          <= nx_rb;
              valC        <= nx_valc;
              valP        <= nx_valp;
              state       <= DONE;
            end
          end
        end
        DONE: begin
          valid     <= 1'b0;
          instr_err <= 1'b0;
          busy      <= 1'b0;
          state     <= IDLE;
        end
        default: begin
          mem.mem_req <= 1'b0;
          busy        <= 1'b0;
          valid       <= 1'b0;
          instr_err   <= 1'b0;
          state       <= IDLE;
        end
      endcase
    end
  end

endmodule
